// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, CTRL bit positions,
// the latched transfer configuration and word-width decoding.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_MSB    = 2;
    localparam int CTRL_CPOL   = 3;
    localparam int CTRL_CPHA   = 4;
    localparam int CTRL_WLO    = 5;
    localparam int CTRL_WHI    = 6;
    localparam int CTRL_RSVD   = 7;
    localparam int CTRL_IRQ_EN = 8;

    typedef struct packed {
        logic       msb;
        logic       cpol;
        logic       cpha;
        logic [1:0] wcode;
    } spi_cfg_t;

    function automatic logic [5:0] width_bits(input logic [1:0] code);
        case (code)
            2'b00:   return 6'd8;
            2'b01:   return 6'd16;
            2'b10:   return 6'd24;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input logic [5:0] w);
        return (w == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer: latches the bit rate at load and emits a one-cycle
// tick every half-period while running, flagged as leading or trailing edge.
module spi_clk_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        run,
    input  logic [31:0] bitrate,
    output logic        tick,
    output logic        lead,
    output logic        trail
);

    logic [31:0] half_q;
    logic [31:0] cnt;
    logic        phase;

    // A bit rate of zero behaves as one so SCK can never stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= 32'd1;
            cnt    <= 32'd0;
            phase  <= 1'b0;
        end else if (load) begin
            half_q <= (bitrate == 32'd0) ? 32'd1 : bitrate;
            cnt    <= (bitrate == 32'd0) ? 32'd0 : bitrate - 32'd1;
            phase  <= 1'b0;
        end else if (tick) begin
            cnt    <= half_q - 32'd1;
            phase  <= ~phase;
        end else if (run) begin
            cnt    <= cnt - 32'd1;
        end
    end

    assign tick  = run && (cnt == 32'd0);
    assign lead  = tick & ~phase;
    assign trail = tick &  phase;

endmodule

// File: rtl/spi_logic_master.sv
// SPI master datapath and FSM (IDLE/LOAD/SHIFT/DONE) for the SoC SPI peripheral.
// Define SPI_LOGIC_MASTER_IRQ_EN to build the completion interrupt; otherwise IRQ_SPI is 0.
module spi_logic_master
    import spi_pkg::*;
(
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic [31:0] SPI_BITRATE,
    input  logic [31:0] SPI_DATA_OUT,
    output logic [31:0] SPI_DATA_IN,
    input  logic [8:0]  SPI_CTRL,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SS,
    output logic        IRQ_SPI
);

    spi_state_e  state;
    spi_cfg_t    cfg;
    logic        start_q;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [6:0]  edge_cnt;
    logic        tick, lead, trail;

    logic        en;
    logic        start_rise;
    logic [5:0]  wid_live;
    logic [5:0]  width;
    logic [31:0] tx_masked;
    logic [31:0] tx_aligned;
    logic        first_bit;
    logic        sample_edge;
    logic        drive_edge;
    logic [31:0] rx_next;
    logic [31:0] rx_final;

    assign en         = SPI_CTRL[CTRL_EN];
    assign start_rise = SPI_CTRL[CTRL_START] & ~start_q;
    assign wid_live   = width_bits(SPI_CTRL[CTRL_WHI:CTRL_WLO]);
    assign width      = width_bits(cfg.wcode);

    // MSB-first words are pre-shifted so the outgoing bit always sits at bit 31.
    assign tx_masked  = SPI_DATA_OUT & width_mask(wid_live);
    assign tx_aligned = SPI_CTRL[CTRL_MSB] ? (tx_masked << (6'd32 - wid_live)) : tx_masked;
    assign first_bit  = SPI_CTRL[CTRL_MSB] ? tx_aligned[31] : tx_aligned[0];

    assign sample_edge = cfg.cpha ? trail : lead;
    assign drive_edge  = cfg.cpha ? lead  : trail;
    assign rx_next     = cfg.msb ? {rx_sr[30:0], MISO} : {MISO, rx_sr[31:1]};
    assign rx_final    = cfg.msb ? rx_sr : (rx_sr >> (6'd32 - width));

    spi_clk_gen u_clk_gen (
        .clk     (clk_cpu),
        .rst_n   (rst),
        .load    (state == ST_LOAD),
        .run     (state == ST_SHIFT),
        .bitrate (SPI_BITRATE),
        .tick    (tick),
        .lead    (lead),
        .trail   (trail)
    );

    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cfg         <= '0;
            start_q     <= 1'b0;
            tx_sr       <= 32'd0;
            rx_sr       <= 32'd0;
            edge_cnt    <= 7'd0;
            SPI_DATA_IN <= 32'd0;
            SCK         <= 1'b0;
            MOSI        <= 1'b0;
            SS          <= 1'b1;
        end else begin
            start_q <= SPI_CTRL[CTRL_START];
            if (!en) begin
                state    <= ST_IDLE;
                edge_cnt <= 7'd0;
                SCK      <= 1'b0;
                MOSI     <= 1'b0;
                SS       <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        SS   <= 1'b1;
                        SCK  <= SPI_CTRL[CTRL_CPOL];
                        MOSI <= 1'b0;
                        if (start_rise) state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        cfg.msb   <= SPI_CTRL[CTRL_MSB];
                        cfg.cpol  <= SPI_CTRL[CTRL_CPOL];
                        cfg.cpha  <= SPI_CTRL[CTRL_CPHA];
                        cfg.wcode <= SPI_CTRL[CTRL_WHI:CTRL_WLO];
                        tx_sr     <= tx_aligned;
                        rx_sr     <= 32'd0;
                        edge_cnt  <= 7'd0;
                        SCK       <= SPI_CTRL[CTRL_CPOL];
                        MOSI      <= first_bit;
                        SS        <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        // The tick after the last SCK edge only pads out the final half-period.
                        if (tick) begin
                            if (edge_cnt == {width, 1'b0}) begin
                                state <= ST_DONE;
                            end else begin
                                SCK      <= ~SCK;
                                edge_cnt <= edge_cnt + 7'd1;
                                if (sample_edge) rx_sr <= rx_next;
                                if (drive_edge) begin
                                    tx_sr <= cfg.msb ? {tx_sr[30:0], 1'b0} : {1'b0, tx_sr[31:1]};
                                    if (cfg.cpha) MOSI <= cfg.msb ? tx_sr[31] : tx_sr[0];
                                    else          MOSI <= cfg.msb ? tx_sr[30] : tx_sr[1];
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        SPI_DATA_IN <= rx_final;
                        SCK         <= cfg.cpol;
                        MOSI        <= 1'b0;
                        SS          <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_LOGIC_MASTER_IRQ_EN
    logic irq_q;
    logic irq_en_q;
    logic ctrl_unused;

    assign ctrl_unused = SPI_CTRL[CTRL_RSVD];

    // Level interrupt: set alongside SS rising, held until the next load or EN drop.
    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (!en) begin
            irq_q    <= 1'b0;
        end else if (state == ST_LOAD) begin
            irq_q    <= 1'b0;
            irq_en_q <= SPI_CTRL[CTRL_IRQ_EN];
        end else if (state == ST_DONE) begin
            irq_q    <= irq_en_q;
        end
    end

    assign IRQ_SPI = irq_q;
`else
    logic [1:0] ctrl_unused;

    assign ctrl_unused = {SPI_CTRL[CTRL_IRQ_EN], SPI_CTRL[CTRL_RSVD]};
    assign IRQ_SPI     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_logic_master.sv
// Directed self-checking bench for spi_logic_master with a cycle-stepped SPI slave model.
module tb_spi_logic_master;

    logic        clk_cpu = 1'b0;
    logic        rst     = 1'b0;
    logic [31:0] bitrate;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic [8:0]  ctrl;
    logic        sck, mosi, miso, ss, irq;

    always #5 clk_cpu = ~clk_cpu;

    spi_logic_master dut (
        .clk_cpu      (clk_cpu),
        .rst          (rst),
        .SPI_BITRATE  (bitrate),
        .SPI_DATA_OUT (data_out),
        .SPI_DATA_IN  (data_in),
        .SPI_CTRL     (ctrl),
        .SCK          (sck),
        .MOSI         (mosi),
        .MISO         (miso),
        .SS           (ss),
        .IRQ_SPI      (irq)
    );

`ifdef SPI_LOGIC_MASTER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_mosi, din_rise;
    logic        irq_rise, irq_pre, irq_fall, sck_idle, sck_rise;
    int          ss_low, n_edges, fall_cyc, rise_cyc, first_edge, last_edge, abort_cyc;
    bit          timed_out;

    function automatic logic sbit(input logic [31:0] wd, input int w, input bit msb, input int i);
        if (i >= w) return 1'b0;
        return msb ? wd[w-1-i] : wd[i];
    endfunction

    // Runs one transfer from a fresh START edge; the slave shifts MISO on its
    // shift edges and captures MOSI on its sample edges.
    task automatic xfer(input logic [8:0] c, input logic [31:0] br, input logic [31:0] dout,
                        input logic [31:0] sword, input int abort_at);
        int  w, im, io;
        bit  msb, cpol, cpha, started, lead_e;
        logic prev;
        w = int'(c[6:5]) * 8 + 8;
        msb = c[2]; cpol = c[3]; cpha = c[4];
        bitrate = br; data_out = dout; miso = 1'b0;
        ctrl = c; ctrl[1] = 1'b0;
        repeat (2) @(negedge clk_cpu);
        sck_idle = sck; prev = sck;
        cap_mosi = 0; ss_low = 0; n_edges = 0; fall_cyc = -1; rise_cyc = -1;
        first_edge = -1; last_edge = -1; abort_cyc = -1; timed_out = 1'b1;
        im = 0; io = 0; started = 1'b0;
        irq_pre = 1'b0; irq_fall = 1'b0; din_rise = 0; irq_rise = 1'b0; sck_rise = 1'b0;
        ctrl[1] = 1'b1;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(negedge clk_cpu);
            if (cyc == 1) irq_pre = irq;
            if (!started && ss == 1'b0) begin
                started = 1'b1; fall_cyc = cyc; irq_fall = irq;
                if (!cpha) miso = sbit(sword, w, msb, 0);
            end
            if (started) begin
                if (ss == 1'b1) begin
                    rise_cyc = cyc; din_rise = data_in; irq_rise = irq; sck_rise = sck;
                    timed_out = 1'b0;
                    break;
                end
                ss_low++;
                if (sck !== prev) begin
                    n_edges++;
                    if (n_edges == 1) first_edge = cyc;
                    last_edge = cyc;
                    lead_e = (sck !== cpol);
                    if (lead_e != cpha) begin
                        if (io < w) cap_mosi[msb ? w-1-io : io] = mosi;
                        io++;
                    end else if (cpha) begin
                        miso = sbit(sword, w, msb, im); im++;
                    end else begin
                        im++; miso = sbit(sword, w, msb, im);
                    end
                    if (n_edges == abort_at) begin ctrl[0] = 1'b0; abort_cyc = cyc; end
                end
                prev = sck;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; ctrl = 9'h1FF; data_out = 32'hDEAD_BEEF; bitrate = 32'd3; miso = 1'b1;
        repeat (3) @(negedge clk_cpu);
        n_tests++; if (ss !== 1'b1) begin n_fail++; $display("FAIL reset_ss got %b want 1", ss); end
        n_tests++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got %b want 0", sck); end
        n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got %b want 0", mosi); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_tests++; if (data_in !== 32'd0) begin n_fail++; $display("FAIL reset_data_in got %h want 0", data_in); end
        ctrl = 9'h000; miso = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_cpu);
    endtask

    task automatic test_mode0;
        xfer(9'h125, 32'd2, 32'd9, 32'h0, 0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL mode0_timeout got %b want 0", timed_out); end
        n_tests++; if (sck_idle !== 1'b0) begin n_fail++; $display("FAIL mode0_sck_idle got %b want 0", sck_idle); end
        n_tests++; if (fall_cyc !== 2) begin n_fail++; $display("FAIL mode0_ss_latency got %0d want 2", fall_cyc); end
        n_tests++; if (first_edge - fall_cyc !== 2) begin n_fail++; $display("FAIL mode0_first_edge got %0d want 2", first_edge - fall_cyc); end
        n_tests++; if (last_edge - first_edge !== 62) begin n_fail++; $display("FAIL mode0_sck_period got %0d want 62", last_edge - first_edge); end
        n_tests++; if (n_edges !== 32) begin n_fail++; $display("FAIL mode0_edges got %0d want 32", n_edges); end
        n_tests++; if (ss_low !== 67) begin n_fail++; $display("FAIL mode0_ss_low got %0d want 67", ss_low); end
        n_tests++; if (cap_mosi !== 32'h0009) begin n_fail++; $display("FAIL mode0_mosi got %h want 00000009", cap_mosi); end
        n_tests++; if (din_rise !== 32'h0) begin n_fail++; $display("FAIL mode0_data_in got %h want 0", din_rise); end
        n_tests++; if (irq_rise !== IRQ_ON) begin n_fail++; $display("FAIL mode0_irq got %b want %b", irq_rise, IRQ_ON); end
        n_tests++; if (irq_fall !== 1'b0) begin n_fail++; $display("FAIL mode0_irq_at_load got %b want 0", irq_fall); end
    endtask

    task automatic test_slave_data;
        xfer(9'h125, 32'd2, 32'd169, 32'hA5C3, 0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL slave_timeout got %b want 0", timed_out); end
        n_tests++; if (din_rise !== 32'h0000_A5C3) begin n_fail++; $display("FAIL slave_data_in got %h want 0000a5c3", din_rise); end
        n_tests++; if (cap_mosi !== 32'h00A9) begin n_fail++; $display("FAIL slave_mosi got %h want 000000a9", cap_mosi); end
        n_tests++; if (ss_low !== 67) begin n_fail++; $display("FAIL slave_ss_low got %0d want 67", ss_low); end
        n_tests++; if (irq_rise !== IRQ_ON) begin n_fail++; $display("FAIL slave_irq got %b want %b", irq_rise, IRQ_ON); end
    endtask

    task automatic test_abort;
        xfer(9'h125, 32'd2, 32'h1234, 32'hFFFF, 5);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL abort_timeout got %b want 0", timed_out); end
        n_tests++; if (rise_cyc - abort_cyc !== 1) begin n_fail++; $display("FAIL abort_ss_delay got %0d want 1", rise_cyc - abort_cyc); end
        n_tests++; if (n_edges !== 5) begin n_fail++; $display("FAIL abort_edges got %0d want 5", n_edges); end
        n_tests++; if (din_rise !== 32'h0000_A5C3) begin n_fail++; $display("FAIL abort_data_in got %h want 0000a5c3", din_rise); end
        n_tests++; if (irq_rise !== 1'b0) begin n_fail++; $display("FAIL abort_irq got %b want 0", irq_rise); end
        n_tests++; if (sck_rise !== 1'b0) begin n_fail++; $display("FAIL abort_sck got %b want 0", sck_rise); end
    endtask

    task automatic test_cpol_cpha;
        xfer(9'h119, 32'd1, 32'h81, 32'h5A, 0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL mode3_timeout got %b want 0", timed_out); end
        n_tests++; if (sck_idle !== 1'b1) begin n_fail++; $display("FAIL mode3_sck_idle got %b want 1", sck_idle); end
        n_tests++; if (n_edges !== 16) begin n_fail++; $display("FAIL mode3_edges got %0d want 16", n_edges); end
        n_tests++; if (cap_mosi !== 32'h81) begin n_fail++; $display("FAIL mode3_mosi got %h want 00000081", cap_mosi); end
        n_tests++; if (din_rise !== 32'h5A) begin n_fail++; $display("FAIL mode3_data_in got %h want 0000005a", din_rise); end
        n_tests++; if (ss_low !== 18) begin n_fail++; $display("FAIL mode3_ss_low got %0d want 18", ss_low); end
        n_tests++; if (sck_rise !== 1'b1) begin n_fail++; $display("FAIL mode3_sck_end got %b want 1", sck_rise); end
        n_tests++; if (irq_rise !== IRQ_ON) begin n_fail++; $display("FAIL mode3_irq got %b want %b", irq_rise, IRQ_ON); end
    endtask

    task automatic test_back_to_back;
        int lows;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_cpu);
            if (ss == 1'b0) lows++;
        end
        n_tests++; if (lows !== 0) begin n_fail++; $display("FAIL retrig_held_start got %0d low cycles want 0", lows); end
        n_tests++; if (irq !== IRQ_ON) begin n_fail++; $display("FAIL retrig_irq_hold got %b want %b", irq, IRQ_ON); end
        n_tests++; if (data_in !== 32'h5A) begin n_fail++; $display("FAIL retrig_data_hold got %h want 0000005a", data_in); end
        xfer(9'h125, 32'd3, 32'h3C, 32'h0F0F, 0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL retrig_timeout got %b want 0", timed_out); end
        n_tests++; if (irq_pre !== IRQ_ON) begin n_fail++; $display("FAIL retrig_irq_before_load got %b want %b", irq_pre, IRQ_ON); end
        n_tests++; if (irq_fall !== 1'b0) begin n_fail++; $display("FAIL retrig_irq_at_load got %b want 0", irq_fall); end
        n_tests++; if (ss_low !== 100) begin n_fail++; $display("FAIL retrig_ss_low got %0d want 100", ss_low); end
        n_tests++; if (cap_mosi !== 32'h3C) begin n_fail++; $display("FAIL retrig_mosi got %h want 0000003c", cap_mosi); end
        n_tests++; if (din_rise !== 32'h0F0F) begin n_fail++; $display("FAIL retrig_data_in got %h want 00000f0f", din_rise); end
        ctrl[0] = 1'b0;
        repeat (2) @(negedge clk_cpu);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL en_off_irq got %b want 0", irq); end
        n_tests++; if (ss !== 1'b1 || sck !== 1'b0) begin n_fail++; $display("FAIL en_off_lines got ss=%b sck=%b want ss=1 sck=0", ss, sck); end
        n_tests++; if (data_in !== 32'h0F0F) begin n_fail++; $display("FAIL en_off_data got %h want 00000f0f", data_in); end
    endtask

    task automatic test_irq_masked;
        xfer(9'h025, 32'd1, 32'h5, 32'h3, 0);
        n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL masked_timeout got %b want 0", timed_out); end
        n_tests++; if (ss_low !== 34) begin n_fail++; $display("FAIL masked_ss_low got %0d want 34", ss_low); end
        n_tests++; if (din_rise !== 32'h3) begin n_fail++; $display("FAIL masked_data_in got %h want 00000003", din_rise); end
        n_tests++; if (irq_rise !== 1'b0) begin n_fail++; $display("FAIL masked_irq got %b want 0", irq_rise); end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_slave_data;
        test_abort;
        test_cpol_cpha;
        test_back_to_back;
        test_irq_masked;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
